// File: rtl/fifo_tx_port_pkg.sv
// Shared constants and state encoding for the FIFO transmit port.
package fifo_tx_port_pkg;

  // Core data width; a transmitted word carries one extra flag bit on top.
  localparam int DATA_WIDTH = 32;

  // Downstream hard FIFO geometry: the space flag is high while count <= 62,
  // which leaves room for one decision made against a stale flag plus one
  // enqueue already in flight.
  localparam int FIFO_DEPTH     = 64;
  localparam int FIFO_SPACE_MAX = 62;

  // Skid buffer capacity.
  localparam logic [1:0] SKID_DEPTH = 2'd2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/fifo_tx_skid.sv
// Two-entry FIFO-ordered skid buffer with a registered ready.
module fifo_tx_skid
  import fifo_tx_port_pkg::*;
#(
  parameter int DW = DATA_WIDTH + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          run_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    count_o,
  output logic          ready_o
);

  logic [DW-1:0] slot0_q, slot0_d;
  logic [DW-1:0] slot1_q, slot1_d;
  logic [1:0]    count_q, count_d;
  logic          ready_q;

  // Next slot contents and occupancy; slot0 is always the head.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) slot0_d = push_data_i;
        else                 slot1_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word queues behind what remains.
        if (count_q == 2'd1) begin
          slot0_d = push_data_i;
        end else begin
          slot0_d = slot1_q;
          slot1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // Occupancy and ready; ready comes up out of reset so the core can start at once.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < SKID_DEPTH) && run_i;
    end
  end

  // Slot storage.
  always_ff @(posedge clk) begin
    // NOTE: data slots are not reset; count_q alone decides which slots are valid.
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign head_o  = slot0_q;
  assign count_o = count_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/fifo_tx_port.sv
// Transmit end of the core-to-FIFO enqueue path: skid buffering, space-flag
// flow control, flush/drain handshake and debug counters.
module fifo_tx_port
  import fifo_tx_port_pkg::*;
#(
  parameter int ID    = 0,
  parameter int DW    = DATA_WIDTH + 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [DW-1:0]    tx_data,
  output logic             tx_enq,
  input  logic             rx_space,
  input  logic             rx_busy,
  input  logic             flush,
  output logic             flush_done,
  output logic             overflow_err,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  tx_state_e        state_q, state_d;
  logic [DW-1:0]    head;
  logic [1:0]       count;
  logic             push, pop;
  logic [DW-1:0]    tx_data_q;
  logic             tx_enq_q;
  logic             overflow_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  assign push = src_valid && src_ready;
  // STALL holds off enqueues for its whole duration; RUN and DRAIN send
  // whenever the FIFO reports space.
  assign pop  = (count != 2'd0) && rx_space && (state_q != ST_STALL);

  fifo_tx_skid #(.DW(DW)) u_skid (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (src_data),
    .pop_i       (pop),
    .run_i       (state_d == ST_RUN),
    .head_o      (head),
    .count_o     (count),
    .ready_o     (src_ready)
  );

  // Next-state logic for the run/stall/drain/done controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (flush)                                 state_d = ST_DRAIN;
        else if ((count != 2'd0) && !rx_space)     state_d = ST_STALL;
      end
      ST_STALL: begin
        if (flush)         state_d = ST_DRAIN;
        else if (rx_space) state_d = ST_RUN;
      end
      ST_DRAIN: begin
        // Wait for the last enqueue strobe to be presented before reporting done.
        if (!flush)                              state_d = ST_RUN;
        else if ((count == 2'd0) && !tx_enq_q)   state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!flush) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State, output strobe/data and debug counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tx_enq_q    <= 1'b0;
      tx_data_q   <= '0;
      overflow_q  <= 1'b0;
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_enq_q <= pop;
      if (pop) tx_data_q <= head;
      if (rx_busy) overflow_q <= 1'b1;
      if (tx_enq_q) word_cnt_q <= word_cnt_q + CNT_W'(1);
      if ((state_q == ST_STALL) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign tx_data      = tx_data_q;
  assign tx_enq       = tx_enq_q;
  assign flush_done   = (state_q == ST_DONE);
  assign overflow_err = overflow_q;
  assign word_cnt     = word_cnt_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fifo_tx_port.sv
// Directed bench for fifo_tx_port with a 64-deep downstream FIFO model.
module tb_fifo_tx_port;
  import fifo_tx_port_pkg::*;

  localparam int DW    = DATA_WIDTH + 1;
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [DW-1:0]    src_data;
  logic             src_valid;
  logic             src_ready;
  logic [DW-1:0]    tx_data;
  logic             tx_enq;
  logic             rx_space;
  logic             rx_busy;
  logic             flush;
  logic             flush_done;
  logic             overflow_err;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Manual drive vs. FIFO model drive of the space/busy flags.
  logic man_space, man_busy;
  logic mdl_space, mdl_busy;
  logic model_en, deq_en;
  logic ovf_pending;
  bit   busy_seen;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] drained[$];

  assign rx_space = model_en ? mdl_space : man_space;
  assign rx_busy  = model_en ? mdl_busy  : man_busy;

  fifo_tx_port #(.ID(0), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .tx_data      (tx_data),
    .tx_enq       (tx_enq),
    .rx_space     (rx_space),
    .rx_busy      (rx_busy),
    .flush        (flush),
    .flush_done   (flush_done),
    .overflow_err (overflow_err),
    .word_cnt     (word_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream FIFO: dequeue first, then accept the enqueue of the ending cycle.
  always @(posedge clk) begin
    if (model_en) begin
      if (deq_en && fifo_q.size() > 0) drained.push_back(fifo_q.pop_front());
      if (tx_enq) begin
        if (fifo_q.size() >= FIFO_DEPTH) ovf_pending = 1'b1;
        else fifo_q.push_back(tx_data);
      end
    end
  end

  // Flags change mid-cycle, away from the DUT's sampling edge.
  always @(negedge clk) begin
    mdl_space   = (fifo_q.size() <= FIFO_SPACE_MAX);
    mdl_busy    = ovf_pending;
    if (ovf_pending) busy_seen = 1'b1;
    ovf_pending = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] w(input int i);
    return DW'(i + 256);
  endfunction

  int sent;
  int n_total;

  // Offer the current word for one cycle and advance on acceptance.
  task automatic step_offer();
    logic fire;
    fire = src_valid && src_ready;
    @(negedge clk);
    if (fire) begin
      sent++;
      if (sent < n_total) src_data = w(sent);
      else                src_valid = 1'b0;
    end
  endtask

  initial begin
    int enq;
    logic [CNT_W-1:0] s0;

    rst = 1'b1; src_data = '0; src_valid = 1'b0; flush = 1'b0;
    man_space = 1'b1; man_busy = 1'b0; model_en = 1'b0; deq_en = 1'b0;
    mdl_space = 1'b1; mdl_busy = 1'b0; ovf_pending = 1'b0; busy_seen = 1'b0;
    sent = 0; n_total = 0;

    // 1. Reset values, then a back-to-back stream of 1..8.
    repeat (2) @(negedge clk);
    check("rst tx_enq", 64'(tx_enq), 64'd0);
    check("rst tx_data", 64'(tx_data), 64'd0);
    check("rst word_cnt", 64'(word_cnt), 64'd0);
    check("rst stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst overflow_err", 64'(overflow_err), 64'd0);
    check("rst flush_done", 64'(flush_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst src_ready", 64'(src_ready), 64'd1);

    src_valid = 1'b1; src_data = DW'(1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("t1 src_ready", 64'(src_ready), 64'd1);
      if (i >= 2 && i <= 9) begin
        check("t1 tx_enq", 64'(tx_enq), 64'd1);
        check("t1 tx_data", 64'(tx_data), 64'(i - 1));
      end else begin
        check("t1 tx_enq idle", 64'(tx_enq), 64'd0);
      end
      if (i < 8) src_data = DW'(i + 1);
      else       src_valid = 1'b0;
    end
    check("t1 word_cnt", 64'(word_cnt), 64'd8);
    check("t1 tx_data hold", 64'(tx_data), 64'd8);

    // 2. Fill a 64-deep FIFO that never dequeues; offer 80 words.
    model_en = 1'b1;
    sent = 0; n_total = 80;
    src_valid = 1'b1; src_data = w(0);
    repeat (150) step_offer();
    check("t2 accepted", 64'(sent), 64'd66);
    check("t2 fifo level", 64'(fifo_q.size()), 64'd64);
    check("t2 busy seen", 64'(busy_seen), 64'd0);
    check("t2 overflow_err", 64'(overflow_err), 64'd0);
    check("t2 src_ready", 64'(src_ready), 64'd0);
    check("t2 word_cnt", 64'(word_cnt), 64'd72);
    s0 = stall_cnt;
    check("t2 stall_cnt nonzero", 64'(s0 != '0), 64'd1);
    repeat (5) step_offer();
    check("t2 stall_cnt +5", 64'(stall_cnt), 64'(s0 + CNT_W'(5)));

    // 3. Dequeue one per cycle; all 80 words must arrive once, in order.
    deq_en = 1'b1;
    for (int c = 0; c < 400 && drained.size() < 80; c++) step_offer();
    @(negedge clk);
    check("t3 drained count", 64'(drained.size()), 64'd80);
    for (int i = 0; i < 80; i++) begin
      if (i < drained.size()) check("t3 order", 64'(drained[i]), 64'(w(i)));
    end
    check("t3 fifo empty", 64'(fifo_q.size()), 64'd0);
    check("t3 busy seen", 64'(busy_seen), 64'd0);
    check("t3 overflow_err", 64'(overflow_err), 64'd0);
    check("t3 src_ready", 64'(src_ready), 64'd1);
    check("t3 word_cnt", 64'(word_cnt), 64'd88);
    s0 = stall_cnt;
    repeat (3) @(negedge clk);
    check("t3 stall_cnt frozen", 64'(stall_cnt), 64'(s0));
    deq_en = 1'b0; model_en = 1'b0; man_space = 1'b1;

    // 4. Two words held by rx_space=0, flush, release space after 5 cycles.
    man_space = 1'b0;
    src_valid = 1'b1; src_data = DW'(12'h0AA);
    @(negedge clk);
    src_data = DW'(12'h0BB);
    @(negedge clk);
    src_valid = 1'b0;
    check("t4 ready when full", 64'(src_ready), 64'd0);
    flush = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4 ready blocked", 64'(src_ready), 64'd0);
      check("t4 no enq", 64'(tx_enq), 64'd0);
      check("t4 not done", 64'(flush_done), 64'd0);
    end
    man_space = 1'b1;
    enq = 0;
    repeat (6) begin
      @(negedge clk);
      check("t4 ready drain", 64'(src_ready), 64'd0);
      if (tx_enq) begin
        check("t4 drain data", 64'(tx_data), (enq == 0) ? 64'h0AA : 64'h0BB);
        enq++;
      end
    end
    check("t4 enq count", 64'(enq), 64'd2);
    check("t4 flush_done", 64'(flush_done), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("t4 done held", 64'(flush_done), 64'd1);
      check("t4 ready in done", 64'(src_ready), 64'd0);
    end
    flush = 1'b0;
    @(negedge clk);
    check("t4 done cleared", 64'(flush_done), 64'd0);
    check("t4 ready back", 64'(src_ready), 64'd1);

    // 5. One-cycle rx_busy pulse sets a sticky error.
    check("t5 err before", 64'(overflow_err), 64'd0);
    man_busy = 1'b1;
    @(negedge clk);
    man_busy = 1'b0;
    @(negedge clk);
    check("t5 err set", 64'(overflow_err), 64'd1);
    repeat (4) @(negedge clk);
    check("t5 err sticky", 64'(overflow_err), 64'd1);

    // 6. Reset with two words buffered and an enqueue about to issue.
    man_space = 1'b0;
    src_valid = 1'b1; src_data = DW'(12'h0CC);
    @(negedge clk);
    src_data = DW'(12'h0DD);
    @(negedge clk);
    src_valid = 1'b0;
    man_space = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6 enq reset cycle", 64'(tx_enq), 64'd0);
    check("t6 word_cnt", 64'(word_cnt), 64'd0);
    check("t6 err cleared", 64'(overflow_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("t6 enq after reset", 64'(tx_enq), 64'd0);
    check("t6 src_ready", 64'(src_ready), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check("t6 buffer discarded", 64'(tx_enq), 64'd0);
    end
    check("t6 word_cnt stays", 64'(word_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_tx_port.md
Name: fifo_tx_port

Overview:
- Transmit end of the core-to-FIFO enqueue interface. Accepts words from a producing core over a valid/ready stream and writes them into a downstream 64-deep hard FIFO via `tx_data`/`tx_enq`.
- Flow control uses the FIFO's space-available flag (`c_out` on the FIFO side, `rx_space` here), so writes never overflow the FIFO.
- Buffers words in a 2-entry skid buffer, supports a flush/drain handshake, and exposes word and stall counters for overlay debug.

Parameters:
- ID, 0, instance identifier, debug only.
- DW, `DATA_WIDTH+1, data word width (from config_5x5.v).
- CNT_W, 16, width of the word and stall counters.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- src_data  input  DW  word from the producing core.
- src_valid  input  1  src_data is valid.
- src_ready  output  1  registered; a transfer occurs when src_valid & src_ready.
- tx_data  output  DW  registered data to the FIFO d_in.
- tx_enq  output  1  registered one-cycle enqueue strobe to the FIFO enq.
- rx_space  input  1  FIFO space flag, high while FIFO count <= 62.
- rx_busy  input  1  FIFO overflow indication.
- flush  input  1  level request to drain and stop accepting input.
- flush_done  output  1  high while drained and flush is held.
- overflow_err  output  1  sticky error flag.
- word_cnt  output  CNT_W  words enqueued since reset, wraps.
- stall_cnt  output  CNT_W  cycles in STALL since reset, saturates.

Behaviour:
- Reset values: all outputs 0 except src_ready = 1 on the cycle after reset. Skid buffer empty, state RUN.
- Skid buffer: 2 entries, FIFO order. Next src_ready = (occupancy after this cycle < 2) & state==RUN.
  - A word offered while src_ready=1 is always captured, even if it fills the buffer.
- Send decision (cycle t): if the buffer is non-empty and rx_space=1, pop the head. At t+1, tx_data = head and tx_enq = 1. Otherwise tx_enq = 0 at t+1.
  - At most one enqueue per cycle.
  - Latency from capture of an empty-buffer word to tx_enq is 2 cycles.
- Margin: the decision uses rx_space while up to 1 enqueue is in flight. The 2-slot margin (flag drops at count 63) guarantees no overflow.
- tx_data holds its last value when tx_enq = 0.
- Simultaneous capture and pop in one cycle: occupancy is unchanged and order is preserved.
- States:
  - RUN: normal operation. Go to STALL when the buffer is non-empty and rx_space=0. Go to DRAIN when flush=1.
  - STALL: no enqueue; stall_cnt increments every cycle. Return to RUN when rx_space=1. Go to DRAIN when flush=1; DRAIN still honours rx_space.
  - DRAIN: src_ready = 0; keep sending under rx_space rules. Go to DONE when the buffer is empty and no tx_enq is pending.
  - DONE: flush_done = 1. Return to RUN when flush=0; src_ready returns the next cycle.
- flush deasserted during DRAIN: return to RUN with the buffer contents preserved.
- word_cnt increments when tx_enq=1, wrapping modulo 2^CNT_W. stall_cnt saturates at all-ones.
- overflow_err: set when rx_busy=1 in any cycle. Cleared only by rst.
- Reset mid-operation: buffered words are discarded and no tx_enq is issued on the reset cycle or the following cycle.

Decomposition:
- Shared package: state encoding localparams (RUN=0, STALL=1, DRAIN=2, DONE=3) and the FIFO depth/margin constants (64, 62).
- One sub-module: fifo_tx_skid, the 2-entry skid buffer with push/pop/occupancy and registered ready.

Test Plan:
1. Reset, hold rx_space=1, stream 0x1..0x8 back-to-back -> tx_enq high 8 consecutive cycles starting 2 cycles after first capture, data in order, word_cnt=8, src_ready never low.
2. Model a 64-deep FIFO with no dequeue and push 80 words -> exactly 64 enqueues, rx_busy never asserted, overflow_err=0, src_ready low after buffer fills, stall_cnt counting.
3. Continue scenario 2, dequeue one word per cycle -> remaining 16 words delivered in order, no loss or duplication, state returns to RUN.
4. Load 2 words with rx_space=0, assert flush, release rx_space after 5 cycles -> src_ready=0 throughout, 2 enqueues, flush_done high until flush drops, src_ready=1 the cycle after.
5. Drive rx_busy=1 for one cycle -> overflow_err=1 and stays 1 until rst.
6. Assert rst with 2 words buffered and tx_enq pending -> no tx_enq on the reset cycle or the next, word_cnt=0, src_ready=1 the cycle after reset releases.
